alu_issue: RTL and testbench
============================

# alu_issue

Instruction issue/writeback sequencer for the Retro16 core: drives the core's `alu` block's operand and operation inputs and consumes its result.
- Accepts one 16-bit instruction per valid/ready handshake and decodes it.
- Reads two source operands from an internal 8×16 register file and presents them, with the 3-bit operation code, to `alu`.
- Samples the combinational `alu` result and writes it back to the destination register.

## Interface
Parameters:
- DATA_W, 16, datapath and register width. Only 16 is supported.

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- instr_valid  in  1  an instruction is offered on `instr`.
- instr_ready  out  1  the block can accept an instruction; high only in IDLE.
- instr  in  16  instruction word, [15:13] op, [12:10] rd, [9:7] rs1, [6:4] rs2, [9:0] imm10.
- alu_operand1  out  16  registered operand A to `alu`.
- alu_operand2  out  16  registered operand B to `alu`.
- alu_operation  out  3  registered operation code to `alu`.
- alu_result  in  16  combinational result from `alu`.
- done  out  1  one-cycle pulse at the end of every accepted instruction.
- illegal  out  1  one-cycle pulse, coincident with `done`, for an undefined op.
- dbg_addr  in  3  debug read address into the register file.
- dbg_data  out  16  combinational register file contents at `dbg_addr`.

## Operation
- Opcodes: 000 SHL, 100 ADD, 101 AND, 110 OR, 111 NOT, 001 LDI, 010/011 illegal.
- State machine: IDLE → READ → EXEC → WB → IDLE.
  - IDLE: `instr_ready`=1. A handshake (`instr_valid` & `instr_ready`) latches `instr` and moves to READ. Otherwise stay in IDLE.
  - READ: load `alu_operand1` ← R[rs1], `alu_operand2` ← R[rs2], `alu_operation` ← op.
    - For LDI, load operand1 ← zero-extended imm10, operand2 ← 0, operation ← 000 (shift by 0 passes the immediate).
    - For illegal ops, load operands ← 0 and operation ← 000.
  - EXEC: ALU outputs are stable. `alu_result` is captured into `result_q` at the end of the cycle.
  - WB: R[rd] ← `result_q` at the end of the cycle, except for illegal ops, where no write occurs. `done`=1; `illegal`=1 if the op was illegal.
- NOT uses operand1 only; operand2 still carries R[rs2] and is ignored.
- All 8 registers are writable; there is no hardwired zero register.
- The block performs no arithmetic itself. Width rules (wrap-around on ADD, shift counts ≥16 giving 0) are whatever `alu` returns; the result is stored unchanged.
- rd == rs1 or rd == rs2: sources are read in READ, before WB, so the old value is used.
- `alu_operand*` and `alu_operation` hold their last values outside READ until the next instruction loads them.
- Reset (any state, including mid-instruction) takes effect asynchronously:
  - State → IDLE.
  - All registers, `alu_operand1/2`, `alu_operation` and `result_q` → 0.
  - `done`, `illegal` → 0; `instr_ready` → 1 once in IDLE.
  - The interrupted instruction is discarded: no writeback and no `done`.

## Timing
- Handshake at cycle N. READ is N+1, EXEC is N+2, WB is N+3 (`done` high).
- The written value is visible on `dbg_data` and to the next instruction's READ from N+4.
- `instr_ready` is high again at N+4. The next handshake can occur at N+4, so throughput is one instruction per 4 cycles.
- `instr` is sampled only on the handshake edge; it may change freely afterwards.
- `alu_operand*` and `alu_operation` are valid for the whole EXEC cycle.
- `alu_result` must settle within EXEC; it is sampled only at the end of EXEC.
- `done` and `illegal` are registered, high for exactly one cycle.

## Structure
- Shared package `retro16_pkg` holds:
  - The opcode enum (`OP_SHL`=000, `OP_LDI`=001, `OP_ADD`=100, `OP_AND`=101, `OP_OR`=110, `OP_NOT`=111).
  - The state enum (IDLE/READ/EXEC/WB).
  - Instruction field position constants and `DATA_W`.
- One sub-module, `reg_file`:
  - 8×16 storage.
  - Two combinational read ports plus the debug read port.
  - One synchronous write port with write enable.
  - Async active-low clear.

## Test plan
- Reset, then `rst_n` high → `instr_ready`=1, `done`=0, `alu_operation`=000, all `dbg_data` reads 0.
- LDI r1,0x005; LDI r2,0x003; ADD r3,r1,r2 → `done` at N+3 for each instruction; R3=0x0008; `alu_operand1`=0x0005 and `alu_operand2`=0x0003 during the ADD's EXEC.
- LDI r1,0x3FF; LDI r2,0x010; SHL r4,r1,r2 → R4=0x0000. Then NOT r5,r1 → R5=0xFC00.
- Instruction op 010 with rd=6 after R6 has been loaded with 0x0123 → `illegal` and `done` pulse together; R6 stays 0x0123.
- ADD r1,r1,r1 with R1=0x8001 → R1=0x0002. Hold `instr_valid` high continuously → exactly one handshake every 4 cycles.
- Assert `rst_n`=0 during EXEC of ADD r7,r1,r2 → no `done`; all outputs and R7=0 immediately; `instr_ready`=1 after release.

Source files
------------

// File: rtl/retro16_pkg.sv
// Shared types and constants for the Retro16 issue/writeback path.
// Opcodes, sequencer states and instruction field positions.
package retro16_pkg;

    localparam int DATA_W  = 16;
    localparam int IMM_W   = 10;
    localparam int OP_LSB  = 13;
    localparam int RD_LSB  = 10;
    localparam int RS1_LSB = 7;
    localparam int RS2_LSB = 4;

    typedef enum logic [2:0] {
        OP_SHL = 3'b000,
        OP_LDI = 3'b001,
        OP_ADD = 3'b100,
        OP_AND = 3'b101,
        OP_OR  = 3'b110,
        OP_NOT = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_EXEC,
        ST_WB
    } state_e;

    // 010 and 011 are the only undefined encodings
    function automatic logic op_legal(input logic [2:0] op);
        return op[2] || !op[1];
    endfunction

endpackage

// File: rtl/alu_issue_if.sv
// Instruction valid/ready handshake between fetch and the issue sequencer.
interface alu_issue_if;
    import retro16_pkg::*;

    logic              instr_valid;
    logic              instr_ready;
    logic [DATA_W-1:0] instr;

    modport master (
        output instr_valid,
        output instr,
        input  instr_ready
    );

    modport slave (
        input  instr_valid,
        input  instr,
        output instr_ready
    );

endinterface

// File: rtl/alu_issue_reg_file.sv
// 8x16 register file: two combinational read ports, one debug read port,
// one synchronous write port, asynchronous clear.
module reg_file
    import retro16_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [2:0]        rs1,
    input  logic [2:0]        rs2,
    input  logic [2:0]        dbg_addr,
    output logic [DATA_W-1:0] rs1_data,
    output logic [DATA_W-1:0] rs2_data,
    output logic [DATA_W-1:0] dbg_data,
    input  logic              we,
    input  logic [2:0]        rd,
    input  logic [DATA_W-1:0] wdata
);

    logic [DATA_W-1:0] mem [8];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[rd] <= wdata;
        end
    end

    assign rs1_data = mem[rs1];
    assign rs2_data = mem[rs2];
    assign dbg_data = mem[dbg_addr];

endmodule

// File: rtl/alu_issue.sv
// Retro16 issue/writeback sequencer: IDLE -> READ -> EXEC -> WB,
// feeding registered operands to the external alu and writing its result back.
module alu_issue #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    alu_issue_if.slave        bus,
    output logic [DATA_W-1:0] alu_operand1,
    output logic [DATA_W-1:0] alu_operand2,
    output logic [2:0]        alu_operation,
    input  logic [DATA_W-1:0] alu_result,
    output logic              done,
    output logic              illegal,
    input  logic [2:0]        dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);
    import retro16_pkg::*;

    state_e            state_q;
    state_e            state_d;
    logic [DATA_W-1:0] ir_q;
    logic [DATA_W-1:0] result_q;
    logic [DATA_W-1:0] rs1_data;
    logic [DATA_W-1:0] rs2_data;
    logic [2:0]        op;
    logic [2:0]        rd;
    logic [2:0]        rs1;
    logic [2:0]        rs2;
    logic              legal;
    logic              hs;
    logic              we;

    assign op    = ir_q[OP_LSB +: 3];
    assign rd    = ir_q[RD_LSB +: 3];
    assign rs1   = ir_q[RS1_LSB +: 3];
    assign rs2   = ir_q[RS2_LSB +: 3];
    assign legal = op_legal(op);
    assign hs    = bus.instr_valid && bus.instr_ready;
    assign we    = (state_q == ST_WB) && legal;

    assign bus.instr_ready = (state_q == ST_IDLE);

    reg_file u_rf (
        .clk      (clk),
        .rst_n    (rst_n),
        .rs1      (rs1),
        .rs2      (rs2),
        .dbg_addr (dbg_addr),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data),
        .dbg_data (dbg_data),
        .we       (we),
        .rd       (rd),
        .wdata    (result_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (bus.instr_valid) state_d = ST_READ;
            ST_READ: state_d = ST_EXEC;
            ST_EXEC: state_d = ST_WB;
            ST_WB:   state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ir_q          <= '0;
            result_q      <= '0;
            alu_operand1  <= '0;
            alu_operand2  <= '0;
            alu_operation <= '0;
            done          <= 1'b0;
            illegal       <= 1'b0;
        end else begin
            done    <= 1'b0;
            illegal <= 1'b0;
            unique case (1'b1)
                hs: ir_q <= bus.instr;
                state_q == ST_READ: begin
                    unique case (1'b1)
                        !legal: begin
                            alu_operand1  <= '0;
                            alu_operand2  <= '0;
                            alu_operation <= OP_SHL;
                        end
                        op == OP_LDI: begin
                            // shift by zero passes the immediate through
                            alu_operand1  <= {{(DATA_W-IMM_W){1'b0}},
                                              ir_q[IMM_W-1:0]};
                            alu_operand2  <= '0;
                            alu_operation <= OP_SHL;
                        end
                        default: begin
                            alu_operand1  <= rs1_data;
                            alu_operand2  <= rs2_data;
                            alu_operation <= op;
                        end
                    endcase
                end
                state_q == ST_EXEC: begin
                    result_q <= alu_result;
                    done     <= 1'b1;
                    illegal  <= !legal;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_issue.sv
// Directed table-driven bench for alu_issue with a behavioural alu model.
module tb_alu_issue;

    logic        clk;
    logic        rst_n;
    logic [15:0] alu_operand1;
    logic [15:0] alu_operand2;
    logic [2:0]  alu_operation;
    logic [15:0] alu_result;
    logic        done;
    logic        illegal;
    logic [2:0]  dbg_addr;
    logic [15:0] dbg_data;

    int n_vec;
    int n_err;

    alu_issue_if bus ();

    alu_issue #(.DATA_W(16)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .bus           (bus.slave),
        .alu_operand1  (alu_operand1),
        .alu_operand2  (alu_operand2),
        .alu_operation (alu_operation),
        .alu_result    (alu_result),
        .done          (done),
        .illegal       (illegal),
        .dbg_addr      (dbg_addr),
        .dbg_data      (dbg_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // external alu behaviour
    always_comb begin
        alu_result = 16'h0000;
        case (alu_operation)
            3'b000: alu_result = (alu_operand2 >= 16) ? 16'h0000
                                 : (alu_operand1 << alu_operand2[3:0]);
            3'b100: alu_result = alu_operand1 + alu_operand2;
            3'b101: alu_result = alu_operand1 & alu_operand2;
            3'b110: alu_result = alu_operand1 | alu_operand2;
            3'b111: alu_result = ~alu_operand1;
            default: alu_result = 16'h0000;
        endcase
    end

    typedef struct {
        logic [15:0] instr;
        logic [15:0] op1;
        logic [15:0] op2;
        logic [2:0]  opc;
        logic        ill;
        logic [2:0]  reg_a;
        logic [15:0] reg_v;
    } vec_t;

    vec_t vecs [15];

    task automatic check(input string name, input logic [15:0] act,
                         input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_ready();
        int k;
        k = 0;
        while (!bus.instr_ready && k < 8) begin
            @(negedge clk);
            k++;
        end
        if (!bus.instr_ready) check("ready_timeout", 16'd0, 16'd1);
    endtask

    task automatic apply(input vec_t v, input int idx);
        logic [3:0]  d;
        logic        ill;
        logic [15:0] o1;
        logic [15:0] o2;
        logic [2:0]  oc;
        @(negedge clk);
        wait_ready();
        bus.instr_valid = 1'b1;
        bus.instr       = v.instr;
        @(posedge clk);
        #1;
        bus.instr_valid = 1'b0;
        bus.instr       = 16'($urandom);
        @(negedge clk);
        d[3] = done;
        @(negedge clk);
        d[2] = done;
        o1 = alu_operand1;
        o2 = alu_operand2;
        oc = alu_operation;
        @(negedge clk);
        d[1] = done;
        ill  = illegal;
        @(negedge clk);
        d[0] = done;
        dbg_addr = v.reg_a;
        #1;
        check($sformatf("v%0d_done_seq", idx), {12'd0, d}, 16'h0002);
        check($sformatf("v%0d_illegal", idx), {15'd0, ill}, {15'd0, v.ill});
        check($sformatf("v%0d_op1", idx), o1, v.op1);
        check($sformatf("v%0d_op2", idx), o2, v.op2);
        check($sformatf("v%0d_opc", idx), {13'd0, oc}, {13'd0, v.opc});
        check($sformatf("v%0d_reg", idx), dbg_data, v.reg_v);
        check($sformatf("v%0d_ready", idx), {15'd0, bus.instr_ready}, 16'h0001);
    endtask

    initial begin
        int cnt;
        int last;
        n_vec = 0;
        n_err = 0;
        //         instr     op1      op2      opc   ill  reg  value
        vecs[0]  = '{16'h2405, 16'h0005, 16'h0000, 3'b000, 1'b0, 3'd1, 16'h0005};
        vecs[1]  = '{16'h2803, 16'h0003, 16'h0000, 3'b000, 1'b0, 3'd2, 16'h0003};
        vecs[2]  = '{16'h8CA0, 16'h0005, 16'h0003, 3'b100, 1'b0, 3'd3, 16'h0008};
        vecs[3]  = '{16'h27FF, 16'h03FF, 16'h0000, 3'b000, 1'b0, 3'd1, 16'h03FF};
        vecs[4]  = '{16'h2810, 16'h0010, 16'h0000, 3'b000, 1'b0, 3'd2, 16'h0010};
        vecs[5]  = '{16'h10A0, 16'h03FF, 16'h0010, 3'b000, 1'b0, 3'd4, 16'h0000};
        vecs[6]  = '{16'hF480, 16'h03FF, 16'h0000, 3'b111, 1'b0, 3'd5, 16'hFC00};
        vecs[7]  = '{16'h3923, 16'h0123, 16'h0000, 3'b000, 1'b0, 3'd6, 16'h0123};
        vecs[8]  = '{16'h58A0, 16'h0000, 16'h0000, 3'b000, 1'b1, 3'd6, 16'h0123};
        vecs[9]  = '{16'h2401, 16'h0001, 16'h0000, 3'b000, 1'b0, 3'd1, 16'h0001};
        vecs[10] = '{16'h280F, 16'h000F, 16'h0000, 3'b000, 1'b0, 3'd2, 16'h000F};
        vecs[11] = '{16'h04A0, 16'h0001, 16'h000F, 3'b000, 1'b0, 3'd1, 16'h8000};
        vecs[12] = '{16'h2C01, 16'h0001, 16'h0000, 3'b000, 1'b0, 3'd3, 16'h0001};
        vecs[13] = '{16'hC4B0, 16'h8000, 16'h0001, 3'b110, 1'b0, 3'd1, 16'h8001};
        vecs[14] = '{16'h8490, 16'h8001, 16'h8001, 3'b100, 1'b0, 3'd1, 16'h0002};

        rst_n           = 1'b0;
        bus.instr_valid = 1'b0;
        bus.instr       = 16'h0000;
        dbg_addr        = 3'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_ready", {15'd0, bus.instr_ready}, 16'h0001);
        check("rst_done", {15'd0, done}, 16'h0000);
        check("rst_opc", {13'd0, alu_operation}, 16'h0000);
        for (int r = 0; r < 8; r++) begin
            dbg_addr = 3'(r);
            #1;
            check($sformatf("rst_r%0d", r), dbg_data, 16'h0000);
        end

        for (int i = 0; i < 15; i++) apply(vecs[i], i);

        // AND r4,r1,r3 : 0x0002 & 0x0001
        apply('{16'hB0B0, 16'h0002, 16'h0001, 3'b101, 1'b0, 3'd4, 16'h0000}, 15);

        // back-to-back: valid held high, LDI r7,0x005
        @(negedge clk);
        wait_ready();
        bus.instr_valid = 1'b1;
        bus.instr       = 16'h3C05;
        cnt  = 0;
        last = -1;
        for (int i = 0; i < 16; i++) begin
            if (bus.instr_ready) begin
                cnt++;
                if (last >= 0) check("hs_gap", 16'(i - last), 16'd4);
                last = i;
            end
            @(negedge clk);
        end
        bus.instr_valid = 1'b0;
        check("hs_count", 16'(cnt), 16'd4);
        dbg_addr = 3'd7;
        #1;
        check("hs_r7", dbg_data, 16'h0005);

        // reset during EXEC of ADD r7,r1,r2
        @(negedge clk);
        wait_ready();
        bus.instr_valid = 1'b1;
        bus.instr       = 16'h9CA0;
        @(posedge clk);
        #1;
        bus.instr_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rr_exec_op1", alu_operand1, 16'h0002);
        check("rr_exec_op2", alu_operand2, 16'h000F);
        rst_n = 1'b0;
        #1;
        check("rr_done", {15'd0, done}, 16'h0000);
        check("rr_op1", alu_operand1, 16'h0000);
        check("rr_op2", alu_operand2, 16'h0000);
        check("rr_r7", dbg_data, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (done) cnt++;
        end
        check("rr_no_done", 16'(cnt), 16'd0);
        check("rr_ready", {15'd0, bus.instr_ready}, 16'h0001);
        dbg_addr = 3'd1;
        #1;
        check("rr_r1", dbg_data, 16'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
